sprite_compositor: RTL and testbench
====================================

Name: sprite_compositor

Overview:
Parametrised successor of the single-ship pixel renderer: composites N_SPRITES bitmap sprites over a solid background into the VGA RGB stream. Each sprite has its own position, colour, integer scale and visibility. Attribute updates are double-buffered and committed at frame start, and pixel-exact sprite-to-sprite collisions are reported once per frame. Sits between the game logic (ship, enemies, shots) and the VGA timing generator.

Parameters:
N_SPRITES, 4, number of sprite layers; index 0 has highest priority
SPR_W, 16, bitmap width in pixels
SPR_H, 16, bitmap height in rows
H_OFFSET, 144, VGA_X value of first visible column
V_OFFSET, 35, VGA_Y value of first visible row
BG_RGB, 24'h003232, background colour {R,G,B}

Ports:
VGA_CLK  in  1  pixel clock
reset  in  1  asynchronous, active-high
VGA_X  in  10  raw horizontal counter
VGA_Y  in  10  raw vertical counter
frame_start  in  1  one-cycle pulse at start of vertical blank
ativo  in  1  game running
perdeu  in  1  game lost
upd_valid  in  1  attribute update request
upd_ready  out  1  attribute update accepted when valid&ready
upd_id  in  clog2(N_SPRITES)  target sprite
upd_x  in  10  sprite left edge, visible-area coordinates
upd_y  in  10  sprite top edge, visible-area coordinates
upd_rgb  in  24  sprite colour
upd_scale  in  2  pixel magnification = 1<<upd_scale (1,2,4,8)
upd_visible  in  1  sprite enable
bm_we  in  1  bitmap row write
bm_id  in  clog2(N_SPRITES)  bitmap sprite select
bm_row  in  clog2(SPR_H)  row index
bm_data  in  SPR_W  row bits; MSB = leftmost column
VGA_R, VGA_G, VGA_B  out  8 each  pixel colour
collision  out  N_SPRITES  per-sprite collision flags of previous frame
collision_any  out  1  OR of collision

Behaviour:
- Reset: all shadow and active attributes cleared (x=y=0, rgb=0, scale=0, visible=0), bitmaps all zero, VGA_R/G/B=0, collision=0, collision_any=0, pipeline flushed.
- Attribute handshake: upd_ready=1 in every cycle except when frame_start=1. A transfer occurs when upd_valid&upd_ready; it writes the shadow set of upd_id. Upd_id >= N_SPRITES is accepted and discarded.
- Commit: on a cycle with frame_start=1, shadow attributes are copied to the active set. Updates presented in that cycle stall (ready=0) and are taken the next cycle.
- Bitmap writes: take effect in the cycle after bm_we and are not double-buffered. Out-of-range bm_id or bm_row is ignored.
- Geometry per sprite i:
  - px = VGA_X-H_OFFSET and py = VGA_Y-V_OFFSET, 10-bit.
  - Hit requires visible, px>=x, py>=y, (px-x)>>scale < SPR_W, (py-y)>>scale < SPR_H, and bitmap bit [row=(py-y)>>scale][col=(px-x)>>scale] = 1.
  - Differences are computed at 11 bits so there is no wrap-around. A sprite clipped by the 640x480 edge is simply not drawn off-screen.
- Pipeline:
  - Stage 1 registers the hit vector and a gating flag (ativo & !perdeu & VGA_X/VGA_Y in visible area).
  - Stage 2 registers RGB.
  - Latency is exactly 2 VGA_CLK cycles from VGA_X/VGA_Y to VGA_R/G/B.
- Colour selection:
  - gating flag=0 → 0.
  - Else the lowest-index hit sprite → its rgb.
  - No hit → BG_RGB.
- Collision:
  - Accumulator acc |= hit vector in any stage-1 cycle where popcount(hit)>=2, only while ativo & !perdeu.
  - On frame_start, collision<=acc (including a hit landing in the same cycle) and acc<=0.
  - collision_any is registered with collision.
- ativo/perdeu changes affect output after the same 2-cycle latency and never disturb attribute or bitmap state.

Test Plan:
- Reset mid-frame with sprites drawn → next cycle RGB=0 and collision=0; after release, upd_ready=1 and the screen is BG only (0,50,50) because visible=0.
- Load sprite 0: all-ones bitmap, x=100, y=50, scale=0, rgb=FF0000. Commit on frame_start; present VGA_X=244, VGA_Y=85 → RGB=FF,00,00 two cycles later. VGA_X=260 → background.
- Set scale=1 on sprite 0 and a bitmap with only row0 MSB set → pixels (100..101, 50..51) red, (102, 50) background.
- Place sprites 0 and 1 overlapping at (100,50), both opaque → the overlap shows sprite 0's colour. At the next frame_start, collision=0011 and collision_any=1; a frame without overlap clears it to 0000.
- Set upd_valid=1 in the same cycle as frame_start → upd_ready=0 that cycle. The transfer completes the next cycle, and the new x appears only after the following frame_start.
- ativo=1, perdeu=1 → RGB=0 after 2 cycles and collision accumulation stops. perdeu=0 → the previous image returns without reload.

Source files
------------

// File: rtl/sprite_compositor.sv
// Multi-sprite compositor for the VGA pixel stream: N bitmap sprites over a solid
// background, double-buffered attributes committed at frame start, per-frame collision flags.
module sprite_compositor #(
  parameter int          N_SPRITES = 4,
  parameter int          SPR_W     = 16,
  parameter int          SPR_H     = 16,
  parameter int          H_OFFSET  = 144,
  parameter int          V_OFFSET  = 35,
  parameter logic [23:0] BG_RGB    = 24'h003232,
  localparam int         ID_W      = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1,
  localparam int         ROW_W     = (SPR_H > 1) ? $clog2(SPR_H) : 1,
  localparam int         COL_W     = (SPR_W > 1) ? $clog2(SPR_W) : 1
) (
  input  logic                 VGA_CLK,
  input  logic                 reset,
  input  logic [9:0]           VGA_X,
  input  logic [9:0]           VGA_Y,
  input  logic                 frame_start,
  input  logic                 ativo,
  input  logic                 perdeu,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [ID_W-1:0]      upd_id,
  input  logic [9:0]           upd_x,
  input  logic [9:0]           upd_y,
  input  logic [23:0]          upd_rgb,
  input  logic [1:0]           upd_scale,
  input  logic                 upd_visible,
  input  logic                 bm_we,
  input  logic [ID_W-1:0]      bm_id,
  input  logic [ROW_W-1:0]     bm_row,
  input  logic [SPR_W-1:0]     bm_data,
  output logic [7:0]           VGA_R,
  output logic [7:0]           VGA_G,
  output logic [7:0]           VGA_B,
  output logic [N_SPRITES-1:0] collision,
  output logic                 collision_any
);

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
    logic [1:0]  scale;
    logic        visible;
  } attr_t;

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(SPR_W - 1);

  attr_t                shadow [N_SPRITES];
  attr_t                active [N_SPRITES];
  logic [SPR_W-1:0]     bitmap [N_SPRITES][SPR_H];

  logic [9:0]           px, py;
  logic [10:0]          dx, dy, dxs, dys;
  logic [N_SPRITES-1:0] hit, hit_q, acc, acc_next;
  logic                 play, on_screen, gate, gate_q, multi;
  logic [23:0]          rgb_sel;

  assign upd_ready = !frame_start;

  // NOTE: every clocked process uses non-blocking assignments so all state
  // samples its inputs from the same edge regardless of process ordering.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (upd_valid && upd_ready && 32'(upd_id) < N_SPRITES)
        shadow[upd_id] <= '{x: upd_x, y: upd_y, rgb: upd_rgb,
                            scale: upd_scale, visible: upd_visible};
      if (frame_start)
        for (int i = 0; i < N_SPRITES; i++) active[i] <= shadow[i];
    end
  end

  // NOTE: the bitmap store is cleared by reset because a blank sprite set is
  // part of the post-reset screen; this keeps it in flops rather than RAM.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_SPRITES; i++)
        for (int r = 0; r < SPR_H; r++) bitmap[i][r] <= '0;
    end else if (bm_we && 32'(bm_id) < N_SPRITES && 32'(bm_row) < SPR_H) begin
      bitmap[bm_id][bm_row] <= bm_data;
    end
  end

  assign px        = VGA_X - 10'(H_OFFSET);
  assign py        = VGA_Y - 10'(V_OFFSET);
  assign play      = ativo && !perdeu;
  assign on_screen = (VGA_X >= 10'(H_OFFSET)) && (VGA_X < 10'(H_OFFSET + 640)) &&
                     (VGA_Y >= 10'(V_OFFSET)) && (VGA_Y < 10'(V_OFFSET + 480));
  assign gate      = play && on_screen;

  // NOTE: every variable written here is assigned before any conditional use,
  // so no path leaves a stale value and no latch is inferred.
  always_comb begin
    hit = '0;
    dx  = '0;
    dy  = '0;
    dxs = '0;
    dys = '0;
    for (int i = 0; i < N_SPRITES; i++) begin
      // 11-bit differences: bit 10 set means the pixel lies left of / above the sprite.
      dx  = {1'b0, px} - {1'b0, active[i].x};
      dy  = {1'b0, py} - {1'b0, active[i].y};
      dxs = dx >> active[i].scale;
      dys = dy >> active[i].scale;
      if (active[i].visible && !dx[10] && !dy[10] &&
          dxs < 11'(SPR_W) && dys < 11'(SPR_H))
        hit[i] = bitmap[i][dys[ROW_W-1:0]][COL_MAX - dxs[COL_W-1:0]];
    end
  end

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      hit_q  <= '0;
      gate_q <= 1'b0;
    end else begin
      hit_q  <= hit;
      gate_q <= gate;
    end
  end

  // Walk from the highest index down so the lowest-index hit wins.
  always_comb begin
    rgb_sel = BG_RGB;
    for (int i = N_SPRITES - 1; i >= 0; i--)
      if (hit_q[i]) rgb_sel = active[i].rgb;
  end

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      {VGA_R, VGA_G, VGA_B} <= 24'h0;
    end else begin
      {VGA_R, VGA_G, VGA_B} <= gate_q ? rgb_sel : 24'h0;
    end
  end

  // Two or more set bits <=> clearing the lowest set bit leaves something.
  assign multi    = |(hit & (hit - N_SPRITES'(1)));
  assign acc_next = (play && multi) ? (acc | hit) : acc;

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      acc           <= '0;
      collision     <= '0;
      collision_any <= 1'b0;
    end else if (frame_start) begin
      collision     <= acc_next;
      collision_any <= |acc_next;
      acc           <= '0;
    end else begin
      acc           <= acc_next;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: reset, commit, scaling, priority,
// collision reporting, handshake stall, game-state gating and mid-run reset.
module tb_sprite_compositor;

  logic        VGA_CLK, reset;
  logic [9:0]  VGA_X, VGA_Y;
  logic        frame_start, ativo, perdeu;
  logic        upd_valid, upd_ready;
  logic [1:0]  upd_id;
  logic [9:0]  upd_x, upd_y;
  logic [23:0] upd_rgb;
  logic [1:0]  upd_scale;
  logic        upd_visible;
  logic        bm_we;
  logic [1:0]  bm_id;
  logic [3:0]  bm_row;
  logic [15:0] bm_data;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic [3:0]  collision;
  logic        collision_any;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  sprite_compositor dut (
    .VGA_CLK(VGA_CLK), .reset(reset), .VGA_X(VGA_X), .VGA_Y(VGA_Y),
    .frame_start(frame_start), .ativo(ativo), .perdeu(perdeu),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_id(upd_id),
    .upd_x(upd_x), .upd_y(upd_y), .upd_rgb(upd_rgb), .upd_scale(upd_scale),
    .upd_visible(upd_visible), .bm_we(bm_we), .bm_id(bm_id), .bm_row(bm_row),
    .bm_data(bm_data), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .collision(collision), .collision_any(collision_any)
  );

  initial VGA_CLK = 1'b0;
  always #5 VGA_CLK = ~VGA_CLK;

  task automatic tick();
    @(posedge VGA_CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [1:0] id, input int x, input int y,
                     input logic [23:0] rgb, input logic [1:0] sc, input logic vis);
    upd_valid = 1'b1; upd_id = id; upd_x = 10'(x); upd_y = 10'(y);
    upd_rgb = rgb; upd_scale = sc; upd_visible = vis;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic bm_write(input logic [1:0] id, input int row, input logic [15:0] data);
    bm_we = 1'b1; bm_id = id; bm_row = 4'(row); bm_data = data;
    tick();
    bm_we = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Present a visible-area pixel, wait the pipeline latency, compare, then park in blanking.
  task automatic pix(input int vx, input int vy, input logic [23:0] exp, input string tag);
    VGA_X = 10'(vx + 144);
    VGA_Y = 10'(vy + 35);
    tick();
    tick();
    check(tag, {VGA_R, VGA_G, VGA_B}, exp);
    VGA_X = '0;
    VGA_Y = '0;
  endtask

  initial begin
    reset = 1'b1; VGA_X = '0; VGA_Y = '0; frame_start = 1'b0;
    ativo = 1'b1; perdeu = 1'b0; upd_valid = 1'b0; upd_id = '0;
    upd_x = '0; upd_y = '0; upd_rgb = '0; upd_scale = '0; upd_visible = 1'b0;
    bm_we = 1'b0; bm_id = '0; bm_row = '0; bm_data = '0;

    // Power-on reset and blank screen.
    tick(); tick();
    check("rst_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
    check("rst_coll", 24'(collision), 24'h0);
    reset = 1'b0;
    tick();
    check("ready_idle", 24'(upd_ready), 24'h1);
    pix(0, 0, 24'h003232, "bg_only");

    // Sprite 0: opaque 16x16 red at (100,50); invisible until committed.
    for (int r = 0; r < 16; r++) bm_write(2'd0, r, 16'hFFFF);
    upd(2'd0, 100, 50, 24'hFF0000, 2'd0, 1'b1);
    pix(100, 50, 24'h003232, "pre_commit");
    frame();
    VGA_X = 10'd244; VGA_Y = 10'd85;
    tick();
    check("latency_1", {VGA_R, VGA_G, VGA_B}, 24'h0);
    tick();
    check("latency_2", {VGA_R, VGA_G, VGA_B}, 24'hFF0000);
    VGA_X = '0; VGA_Y = '0;
    pix(116, 50, 24'h003232, "right_edge");
    pix(115, 65, 24'hFF0000, "far_corner");
    pix(99, 50, 24'h003232, "left_of");
    pix(100, 66, 24'h003232, "below");
    VGA_X = 10'd143; VGA_Y = 10'd85;
    tick(); tick();
    check("hblank", {VGA_R, VGA_G, VGA_B}, 24'h0);

    // Scale 2 with a single-pixel bitmap at row 0, leftmost column.
    for (int r = 0; r < 16; r++) bm_write(2'd0, r, (r == 0) ? 16'h8000 : 16'h0000);
    upd(2'd0, 100, 50, 24'hFF0000, 2'd1, 1'b1);
    frame();
    pix(100, 50, 24'hFF0000, "scale_00");
    pix(101, 51, 24'hFF0000, "scale_11");
    pix(102, 50, 24'h003232, "scale_20");
    pix(100, 52, 24'h003232, "scale_02");

    // Sprites 0 and 1 overlapping: priority and collision reporting.
    for (int r = 0; r < 16; r++) bm_write(2'd0, r, 16'hFFFF);
    for (int r = 0; r < 16; r++) bm_write(2'd1, r, 16'hFFFF);
    upd(2'd0, 100, 50, 24'hFF0000, 2'd0, 1'b1);
    upd(2'd1, 100, 50, 24'h00FF00, 2'd0, 1'b1);
    frame();
    check("coll_none", 24'(collision), 24'h0);
    pix(105, 55, 24'hFF0000, "priority");
    frame();
    check("coll_pair", 24'(collision), 24'h3);
    check("coll_any", 24'(collision_any), 24'h1);
    upd(2'd1, 300, 200, 24'h00FF00, 2'd0, 1'b1);
    frame();
    check("coll_clear", 24'(collision), 24'h0);
    check("coll_any_clr", 24'(collision_any), 24'h0);
    pix(300, 200, 24'h00FF00, "spr1_moved");

    // Update presented together with frame_start stalls, lands next cycle, shows a frame later.
    frame_start = 1'b1;
    upd_valid = 1'b1; upd_id = 2'd1; upd_x = 10'd400; upd_y = 10'd200;
    upd_rgb = 24'h00FF00; upd_scale = 2'd0; upd_visible = 1'b1;
    #1;
    check("ready_stall", 24'(upd_ready), 24'h0);
    tick();
    frame_start = 1'b0;
    #1;
    check("ready_after", 24'(upd_ready), 24'h1);
    tick();
    upd_valid = 1'b0;
    pix(300, 200, 24'h00FF00, "old_x_held");
    pix(400, 200, 24'h003232, "new_x_pending");
    frame();
    pix(400, 200, 24'h00FF00, "new_x_live");
    pix(300, 200, 24'h003232, "old_x_gone");

    // Game lost: blank output, no collision accumulation, image returns on resume.
    perdeu = 1'b1;
    pix(400, 200, 24'h0, "lost_blank");
    upd(2'd0, 400, 200, 24'hFF0000, 2'd0, 1'b1);
    frame();
    pix(405, 205, 24'h0, "lost_overlap");
    frame();
    check("lost_no_coll", 24'(collision), 24'h0);
    perdeu = 1'b0;
    pix(405, 205, 24'hFF0000, "resume");
    ativo = 1'b0;
    pix(405, 205, 24'h0, "inactive");
    ativo = 1'b1;
    pix(410, 210, 24'hFF0000, "resume_2");
    frame();
    check("resume_coll", 24'(collision), 24'h3);

    // Reset in the middle of a drawn sprite.
    VGA_X = 10'd549; VGA_Y = 10'd240;
    tick(); tick();
    reset = 1'b1;
    #1;
    check("midrst_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
    check("midrst_coll", 24'(collision), 24'h0);
    check("midrst_any", 24'(collision_any), 24'h0);
    tick();
    reset = 1'b0;
    tick();
    check("midrst_ready", 24'(upd_ready), 24'h1);
    frame();
    pix(405, 205, 24'h003232, "midrst_bg");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
